// File: rtl/ram_test_pkg.sv
// Shared types and March C- element tables for the RAM self-test initiator.
// Bit i of each table describes march element Mi.
package ram_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int NUM_ELEM = 6;

  // M0 ^w0, M1 ^r0w1, M2 ^r1w0, M3 vr0w1, M4 vr1w0, M5 ^r0
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN      = 6'b011000;
  localparam logic [NUM_ELEM-1:0] ELEM_HAS_READ  = 6'b111110;
  localparam logic [NUM_ELEM-1:0] ELEM_EXP_ONE   = 6'b010100;
  localparam logic [NUM_ELEM-1:0] ELEM_WR_ONE    = 6'b001010;
  localparam logic [NUM_ELEM-1:0] ELEM_HAS_WRITE = 6'b011111;

  // Looks up an element's table bit; out-of-range elements read as 0.
  function automatic logic elem_flag(input logic [NUM_ELEM-1:0] tbl, input logic [2:0] elem);
    logic flag;
    flag = 1'b0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      if (elem == 3'(i)) flag = tbl[i];
    end
    return flag;
  endfunction

endpackage

// File: rtl/march_addr_seq.sv
// Up/down address counter for one march element, loadable to 0 or to the
// top address, with a terminal-count flag that follows the direction.
module march_addr_seq #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              load_max,
  input  logic              en,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Address register: load takes priority over stepping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_max ? ADDR_MAX : '0;
    end else if (en) begin
      addr <= down ? (addr - ADDR_ONE) : (addr + ADDR_ONE);
    end else begin
      addr <= addr;
    end
  end

  assign tc = down ? (addr == '0) : (addr == ADDR_MAX);

endmodule

// File: rtl/ram_march_tester.sv
// March C- built-in self-test initiator: sequences the RAM port through six
// march elements, compares every read and records pass/fail and first failure.
module ram_march_tester
  import ram_test_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [DATA_W-1:0] WORD_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};
  localparam logic [7:0]        ERR_MAX   = 8'd255;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        elem;
  logic [2:0]        elem_nxt;
  logic [2:0]        elem_inc;
  logic              seq_load;
  logic              seq_load_max;
  logic              seq_en;
  logic              seq_down;
  logic              seq_tc;
  logic [ADDR_W-1:0] seq_addr;
  logic              start_acc;
  logic              to_fin;
  logic              mismatch;
  logic [DATA_W-1:0] exp_word;
  logic [DATA_W-1:0] wr_word;
  logic [7:0]        err_nxt;

  assign elem_inc = elem + 3'd1;
  assign seq_down = elem_flag(ELEM_DOWN, elem);
  assign exp_word = elem_flag(ELEM_EXP_ONE, elem) ? WORD_ONES : WORD_ZERO;
  assign wr_word  = elem_flag(ELEM_WR_ONE, elem) ? WORD_ONES : WORD_ZERO;
  assign mismatch = (state == RD) && (ram_data_out != exp_word);
  assign err_nxt  = (mismatch && (err_count != ERR_MAX)) ? (err_count + 8'd1) : err_count;

  march_addr_seq #(
    .ADDR_W(ADDR_W)
  ) u_addr_seq (
    .clk     (clk),
    .reset   (reset),
    .load    (seq_load),
    .load_max(seq_load_max),
    .en      (seq_en),
    .down    (seq_down),
    .addr    (seq_addr),
    .tc      (seq_tc)
  );

  // State and element registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      elem  <= 3'd0;
    end else begin
      state <= state_nxt;
      elem  <= elem_nxt;
    end
  end

  // Next-state logic and address-counter control.
  always_comb begin
    state_nxt    = state;
    elem_nxt     = elem;
    seq_load     = 1'b0;
    seq_load_max = 1'b0;
    seq_en       = 1'b0;
    start_acc    = 1'b0;
    to_fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = WR;
          elem_nxt  = 3'd0;
          seq_load  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      WR: begin
        // Last address of the element: reload for the next element.
        if (seq_tc) begin
          elem_nxt     = elem_inc;
          seq_load     = 1'b1;
          seq_load_max = elem_flag(ELEM_DOWN, elem_inc);
          state_nxt    = elem_flag(ELEM_HAS_READ, elem_inc) ? RD : WR;
        end else begin
          seq_en    = 1'b1;
          state_nxt = elem_flag(ELEM_HAS_READ, elem) ? RD : WR;
        end
      end
      RD: begin
        if (elem_flag(ELEM_HAS_WRITE, elem)) begin
          state_nxt = WR;
        end else if (seq_tc) begin
          state_nxt = FIN;
          to_fin    = 1'b1;
        end else begin
          seq_en    = 1'b1;
          state_nxt = RD;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Result registers: cleared on an accepted start, updated on read compares.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass      <= 1'b0;
      err_count <= 8'd0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_elem <= 3'd0;
    end else if (start_acc) begin
      pass      <= 1'b0;
      err_count <= 8'd0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_elem <= 3'd0;
    end else begin
      err_count <= err_nxt;
      if (mismatch && (err_count == 8'd0)) begin
        fail_addr <= seq_addr;
        fail_data <= ram_data_out;
        fail_elem <= elem;
      end
      if (to_fin) begin
        pass <= (err_nxt == 8'd0);
      end
    end
  end

  assign busy        = (state == WR) || (state == RD);
  assign done        = (state == FIN);
  assign ram_we      = (state == WR);
  assign ram_re      = (state == RD);
  assign ram_addr    = busy ? seq_addr : '0;
  assign ram_data_in = ram_we ? wr_word : WORD_ZERO;

endmodule

// File: tb/tb_ram_march_tester.sv
// Self-checking bench: behavioural 16x4 RAM with injectable faults, a March C-
// reference model, table-driven scenarios, random faults and reset corner cases.
module tb_ram_march_tester;

  logic       clk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [3:0] fail_addr;
  logic [3:0] fail_data;
  logic [2:0] fail_elem;
  logic [3:0] ram_addr;
  logic [3:0] ram_data_in;
  logic       ram_we;
  logic       ram_re;
  logic [3:0] ram_data_out;

  ram_march_tester #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data), .fail_elem(fail_elem),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we), .ram_re(ram_re),
    .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fault kind 0 none; 1 stuck-at (p0 addr, p1 bit, p2 value); 2 coupling (write p0 inverts p1)
  int fk, p0, p1, p2;
  int nvec, nfail;
  logic [3:0] mem [16];
  logic [3:0] rd_word;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_data_in;
      if (fk == 2 && int'(ram_addr) == p0) mem[p1[3:0]] <= ~mem[p1[3:0]];
    end
  end

  always_comb begin
    rd_word = mem[ram_addr];
    if (fk == 1 && int'(ram_addr) == p0) rd_word[p1[1:0]] = p2[0];
    ram_data_out = ram_re ? rd_word : 4'd0;
  end

  typedef struct packed {
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [3:0] data;
  } op_t;

  op_t exp_ops[$];
  int  m_err, m_fa, m_fd, m_fe;
  bit  m_pass;

  // March C- as a list of elements: direction, read?, read value, write?, write value
  int el_down [6] = '{0, 0, 0, 1, 1, 0};
  int el_rd   [6] = '{0, 1, 1, 1, 1, 1};
  int el_rv   [6] = '{0, 0, 1, 0, 1, 0};
  int el_wr   [6] = '{1, 1, 1, 1, 1, 0};
  int el_wv   [6] = '{0, 1, 0, 1, 0, 0};

  task automatic build_ref();
    logic [3:0] m [16];
    logic [3:0] rd, ev, wv;
    int a;
    exp_ops.delete();
    m_err = 0; m_fa = 0; m_fd = 0; m_fe = 0;
    for (int i = 0; i < 16; i++) m[i] = 4'd0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 16; k++) begin
        a = (el_down[e] != 0) ? 15 - k : k;
        if (el_rd[e] != 0) begin
          exp_ops.push_back('{1'b0, 1'b1, 4'(a), 4'd0});
          rd = m[a[3:0]];
          if (fk == 1 && a == p0) rd[p1[1:0]] = p2[0];
          ev = (el_rv[e] != 0) ? 4'hF : 4'h0;
          if (rd != ev) begin
            if (m_err == 0) begin m_fa = a; m_fd = int'(rd); m_fe = e; end
            if (m_err < 255) m_err++;
          end
        end
        if (el_wr[e] != 0) begin
          wv = (el_wv[e] != 0) ? 4'hF : 4'h0;
          exp_ops.push_back('{1'b1, 1'b0, 4'(a), wv});
          m[a[3:0]] = wv;
          if (fk == 2 && a == p0) m[p1[3:0]] = ~m[p1[3:0]];
        end
      end
    end
    m_pass = (m_err == 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, 32'({busy, done, pass, err_count, fail_addr, fail_data, fail_elem,
                 ram_addr, ram_data_in, ram_we, ram_re}), 32'd0);
  endtask

  task automatic run_test(input bit hold, input bit e_pass, input int e_err,
                          input int e_fa, input int e_fd, input int e_fe);
    int  nwe, nre;
    op_t o;
    nwe = 0; nre = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      if (c > 1) @(negedge clk);
      o = exp_ops[c-1];
      chk($sformatf("bus[%0d]", c), 32'({busy, done, ram_we, ram_re, ram_addr, ram_data_in}),
          32'({1'b1, 1'b0, o.we, o.re, o.addr, o.data}));
      nwe += int'(ram_we);
      nre += int'(ram_re);
    end
    @(negedge clk);
    chk("done_at_161", 32'({busy, done, ram_we, ram_re, ram_addr, ram_data_in}),
        32'({1'b0, 1'b1, 10'd0}));
    chk("write_count", nwe, 80);
    chk("read_count", nre, 80);
    chk("pass", 32'(pass), 32'(e_pass));
    chk("err_count", 32'(err_count), e_err);
    chk("fail_addr", 32'(fail_addr), e_fa);
    chk("fail_data", 32'(fail_data), e_fd);
    chk("fail_elem", 32'(fail_elem), e_fe);
    @(negedge clk);
    chk("idle_after_done", 32'({busy, done}), 32'd0);
    chk("pass_hold", 32'(pass), 32'(e_pass));
    if (hold) begin
      @(negedge clk);
      chk("restart_cleared", 32'({busy, pass, err_count, fail_addr, fail_data, fail_elem}),
          32'({1'b1, 1'b0, 8'd0, 4'd0, 4'd0, 3'd0}));
      start = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (done) break;
      end
      chk("restart_done", 32'(done), 32'd1);
      chk("restart_err", 32'(err_count), e_err);
    end
  endtask

  typedef struct {
    int fk, p0, p1, p2;
    bit hold;
    bit e_pass;
    int e_err, e_fa, e_fd, e_fe;
  } vec_t;

  vec_t tbl [4];

  initial begin
    nvec = 0; nfail = 0;
    fk = 0; p0 = 0; p1 = 0; p2 = 0;
    tbl[0] = '{0, 0, 0, 0, 1'b0, 1'b1, 0, 0, 0, 0};
    tbl[1] = '{1, 5, 2, 1, 1'b0, 1'b0, 3, 5, 4, 1};
    tbl[2] = '{2, 3, 4, 0, 1'b0, 1'b0, 4, 4, 15, 1};
    tbl[3] = '{1, 5, 2, 1, 1'b1, 1'b0, 3, 5, 4, 1};

    start = 1'b0;
    reset = 1'b0;
    #12;
    chk_all_zero("reset_state");
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk_all_zero("idle_after_reset");

    for (int t = 0; t < 4; t++) begin
      fk = tbl[t].fk; p0 = tbl[t].p0; p1 = tbl[t].p1; p2 = tbl[t].p2;
      build_ref();
      run_test(tbl[t].hold, tbl[t].e_pass, tbl[t].e_err, tbl[t].e_fa, tbl[t].e_fd, tbl[t].e_fe);
      repeat (2) @(negedge clk);
    end

    for (int r = 0; r < 6; r++) begin
      fk = int'($urandom_range(2));
      p0 = int'($urandom_range(15));
      p1 = (fk == 1) ? int'($urandom_range(3)) : (p0 + 1 + int'($urandom_range(14))) % 16;
      p2 = int'($urandom_range(1));
      if (fk == 0) begin p0 = 0; p1 = 0; p2 = 0; end
      build_ref();
      repeat (int'($urandom_range(3))) @(negedge clk);
      run_test(1'b0, m_pass, m_err, m_fa, m_fd, m_fe);
    end

    // Reset in the middle of a test abandons it; a fresh run must pass.
    fk = 0; p0 = 0; p1 = 0; p2 = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (69) @(negedge clk);
    chk("busy_at_70", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1 chk_all_zero("mid_test_reset");
    @(negedge clk); reset = 1'b1;
    build_ref();
    run_test(1'b0, 1'b1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
